// File: rtl/esn_pe_pkg.sv
// Shared definitions for the ESN PE tile and its sequencer: default tile
// geometry, the tanh-LUT latency, and the sequencer state encoding.
package esn_pe_pkg;

  localparam int DEF_WORD_LEN = 16;
  localparam int DEF_NEU_IN   = 8;
  localparam int DEF_NEU_OUT  = 4;

  // Cycles from stable D/W to a valid tanh-LUT output; the LUT reads this too.
  localparam int DEF_TF_LAT   = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    LOAD    = 3'd2,
    SETTLE  = 3'd3,
    FIRE    = 3'd4,
    CAPTURE = 3'd5,
    DONE    = 3'd6
  } state_t;

endpackage

// File: rtl/esn_pe_sched.sv
// Sequencer that time-multiplexes one PE tile over N_GROUPS weight banks and
// gathers every bank's tanh outputs into one result vector, bit-exact.
module esn_pe_sched
  import esn_pe_pkg::*;
#(
  parameter int WORD_LEN = DEF_WORD_LEN,
  parameter int NEU_IN   = DEF_NEU_IN,
  parameter int NEU_OUT  = DEF_NEU_OUT,
  parameter int N_GROUPS = 2,
  parameter int TF_LAT   = DEF_TF_LAT,
  parameter int ADDR_W   = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [WORD_LEN*NEU_IN-1:0]            u_in,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  wmem_rd,
  output logic [ADDR_W-1:0]                     wmem_addr,
  input  logic [WORD_LEN*NEU_IN*NEU_OUT-1:0]    wmem_data,
  output logic [WORD_LEN*NEU_IN-1:0]            pe_d,
  output logic [WORD_LEN*NEU_IN*NEU_OUT-1:0]    pe_w,
  output logic                                  pe_ce,
  input  logic [WORD_LEN*NEU_OUT-1:0]           pe_q,
  output logic [WORD_LEN*NEU_OUT*N_GROUPS-1:0]  x_out,
  output logic                                  x_valid,
  output state_t                                dbg_state
);

  // Handshake: start is a request sampled only while busy is low (IDLE); it is
  // never queued, so a start seen while busy is dropped. Each accepted start
  // yields exactly one done pulse unless rst abandons the pass.

  localparam int GW    = WORD_LEN * NEU_OUT;
  localparam int CNT_W = $clog2(TF_LAT + 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] grp;
  logic [CNT_W-1:0]  settle_cnt;
  logic              grp_last;
  logic              settle_last;

  assign grp_last    = (grp == ADDR_W'(N_GROUPS - 1));
  assign settle_last = (settle_cnt == CNT_W'(TF_LAT - 1));
  assign dbg_state   = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   state_nxt = LOAD;
      LOAD:    state_nxt = SETTLE;
      SETTLE:  if (settle_last) state_nxt = FIRE;
      FIRE:    state_nxt = CAPTURE;
      CAPTURE: state_nxt = grp_last ? DONE : FETCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    wmem_rd   = (state == FETCH);
    wmem_addr = (state == FETCH) ? grp : '0;
    pe_ce     = (state == FIRE);
  end

  // D/W registers stay frozen outside their load points so the LUT can settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      grp        <= '0;
      settle_cnt <= '0;
      pe_d       <= '0;
      pe_w       <= '0;
      x_out      <= '0;
      x_valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pe_d    <= u_in;
            grp     <= '0;
            x_valid <= 1'b0;
          end
        end
        LOAD: begin
          pe_w       <= wmem_data;
          settle_cnt <= '0;
        end
        SETTLE: settle_cnt <= settle_cnt + CNT_W'(1);
        CAPTURE: begin
          for (int g = 0; g < N_GROUPS; g++) begin
            if (grp == ADDR_W'(g)) x_out[g*GW +: GW] <= pe_q;
          end
          if (!grp_last) grp <= grp + ADDR_W'(1);
        end
        DONE: x_valid <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
